bids22_bidder_agent: RTL
========================

# bids22_bidder_agent

Autonomous bidder that drives one bidder port (X, Y or Z) of the bids22 auction block. It is configured with a spending limit and a bid increment. It watches the published `maxBid`, issues single-cycle bids, and tracks ack/err responses with a timeout. It records round outcome on `roundOver`. Three instances, one per bidder port, form the bidder side of the auction testbed and demo top.

## Interface
- `TIMEOUT`, default 8: cycles to wait in WAIT for `ack`/`err` before re-evaluating.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `agent_en` in 1: level enable; low forces IDLE.
- `bid_limit` in 16: maximum amount the agent will ever bid.
- `bid_step` in 16: increment over `maxBid`; 0 is treated as 1.
- `retract_req` in 1: single-cycle request to retract the leading bid.
- `ack`, `err` in 1, 2: auction response. `err` codes: 00 none, 01 insufficient funds, 10 bid too low, 11 round inactive.
- `win`, `roundOver` in 1, 1: round result and end-of-round strobe.
- `maxBid`, `balance` in 32, 32: current highest bid and this bidder's balance.
- `bid`, `bidAmt`, `retract` out 1, 16, 1: drive the auction bidder port.
- `leading` out 1: the agent's last acked bid is still highest.
- `won` out 1: sticky `win` captured at `roundOver`; cleared when the next EVAL is entered.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: single-cycle pulse on timeout.

## Operation
- States: IDLE, EVAL, BID, WAIT, LEAD, STOP.
- IDLE: `agent_en` high -> EVAL.
- EVAL:
  - `amt = min(maxBid + max(bid_step,1), bid_limit)`, summed at 33 bits so there is no wrap.
  - `maxBid >= bid_limit` -> STOP.
  - `amt > balance` -> STOP.
  - otherwise latch `amt` -> BID.
- BID: `bid`=1 and `bidAmt`=`amt` for exactly one cycle -> WAIT; timer cleared.
- WAIT:
  - `err`=01 or 11 -> STOP.
  - `err`=10 -> EVAL.
  - `ack` with `err`=00 -> LEAD; `lead_amt` is set to `amt`.
  - `ack` and nonzero `err` together -> `err` wins.
  - timer reaching `TIMEOUT` -> pulse `timeout_err`, then EVAL.
- LEAD:
  - `leading`=1.
  - `maxBid > lead_amt` -> EVAL (outbid).
  - `retract_req` -> `retract`=1 for one cycle, then STOP.
- STOP: idle outputs until `roundOver`.
- Global priority, highest first: reset > `roundOver` > `!agent_en` > state logic.
  - `roundOver` in any non-IDLE state: `won` <= `win`, next state IDLE. A `retract_req` in the same cycle is dropped.
  - `agent_en` low in any state: next state IDLE, and any pending response is discarded.
- `retract_req` outside LEAD is ignored.
- `bidAmt` is 0 whenever `bid` is 0.

## Timing
- Reset values: `bid`, `bidAmt`, `retract`, `leading`, `won`, `busy` and `timeout_err` are all 0. State is IDLE, `lead_amt` is 0, and stats counters are 0.
- All outputs are registered.
- Bid latency: with `agent_en` first sampled high at edge k, EVAL is entered at k+1 and `bid` is high from edge k+2 to k+3.
- Response window: `ack`/`err` is sampled from the first edge after `bid` falls, for `TIMEOUT` edges. `timeout_err` rises on the edge where the count reaches `TIMEOUT`.
- Outbid reaction: `maxBid` exceeding `lead_amt` at edge j gives EVAL at j+1 and `bid` at j+2.
- `retract` asserts at the edge after `retract_req` is sampled in LEAD.
- Reset mid-bid deasserts `bid` immediately (asynchronous).

## Configuration
- `BIDS22_AGENT_STATS_EN` defined adds two output ports, each 16 bits, saturating at 0xFFFF:
  - `bid_count`: increments on every acked bid.
  - `win_count`: increments when `roundOver` is sampled with `win`=1.
- Without the macro, these ports and their counters do not exist.

## Structure
- `bids22_pkg` holds:
  - `bids22_err_e` (the four `err` codes);
  - the agent state enum;
  - bid-width constants (16) and balance-width constants (32).
- Sub-module `bids22_bid_calc` is combinational. Inputs: `maxBid`, `bid_step`, `bid_limit`, `balance`. Outputs: `amt` and a `give_up` flag. It is instantiated once and isolates the saturating arithmetic.

## Test plan
- Reset asserted while in WAIT -> all outputs 0 in the same cycle; after release the agent stays IDLE until `agent_en`.
- `maxBid`=100, `bid_step`=10, `bid_limit`=500, `balance`=1000, `agent_en`=1 -> one-cycle `bid` with `bidAmt`=110. `ack` two cycles later -> `leading`=1.
- In LEAD, `maxBid` rises to 120 -> `leading`=0 and `bid` two cycles later with `bidAmt`=130.
- `maxBid`=495, `bid_step`=10 -> `bidAmt`=500. After ack, `maxBid`=500 with no outbid -> stays LEAD. `maxBid`=501 -> STOP with no `bid`.
- `TIMEOUT`=8, no response -> `timeout_err` pulse 8 cycles after `bid` falls, then a re-bid with the recomputed `amt`.
- Response `err`=01 -> STOP, no further bids. Then `roundOver`=1 with `win`=1 -> `won`=1 and the agent returns to IDLE. With the stats macro, `win_count`=1.

Source files
------------

// File: rtl/bids22_pkg.sv
// Shared types and widths for the bids22 auction bidder side.
// Holds the auction error codes, the agent state encoding and the bid/balance widths.
package bids22_pkg;

  localparam int BIDS22_BID_W = 16;
  localparam int BIDS22_BAL_W = 32;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_FUNDS    = 2'b01,
    ERR_LOW      = 2'b10,
    ERR_INACTIVE = 2'b11
  } bids22_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_BID,
    ST_WAIT,
    ST_LEAD,
    ST_STOP
  } bids22_agent_state_e;

endpackage

// File: rtl/bids22_bid_calc.sv
// Next bid amount: min(maxBid + max(step,1), limit), summed at 33 bits; purely combinational.
// give_up flags a limit already reached or an amount the balance cannot cover.
module bids22_bid_calc
  import bids22_pkg::*;
(
  input  logic [BIDS22_BAL_W-1:0] maxBid,
  input  logic [BIDS22_BID_W-1:0] bid_step,
  input  logic [BIDS22_BID_W-1:0] bid_limit,
  input  logic [BIDS22_BAL_W-1:0] balance,
  output logic [BIDS22_BID_W-1:0] amt,
  output logic                    give_up
);

  logic [BIDS22_BID_W-1:0] step_eff;
  logic [BIDS22_BAL_W:0]   sum;

  always_comb begin
    step_eff = (bid_step == '0) ? 16'd1 : bid_step;
    sum      = {1'b0, maxBid} + 33'(step_eff);
    amt      = (sum > 33'(bid_limit)) ? bid_limit : sum[BIDS22_BID_W-1:0];
    give_up  = (maxBid >= 32'(bid_limit)) || (32'(amt) > balance);
  end

endmodule

// File: rtl/bids22_bidder_agent.sv
// Autonomous bidder for one bids22 port; bid pulses two edges after agent_en is seen, outputs registered.
// No backpressure: waits TIMEOUT edges for ack/err; BIDS22_AGENT_STATS_EN adds bid_count/win_count.
module bids22_bidder_agent
  import bids22_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    agent_en,
  input  logic [BIDS22_BID_W-1:0] bid_limit,
  input  logic [BIDS22_BID_W-1:0] bid_step,
  input  logic                    retract_req,
  input  logic                    ack,
  input  logic [1:0]              err,
  input  logic                    win,
  input  logic                    roundOver,
  input  logic [BIDS22_BAL_W-1:0] maxBid,
  input  logic [BIDS22_BAL_W-1:0] balance,
  output logic                    bid,
  output logic [BIDS22_BID_W-1:0] bidAmt,
  output logic                    retract,
  output logic                    leading,
  output logic                    won,
  output logic                    busy,
  output logic                    timeout_err
`ifdef BIDS22_AGENT_STATS_EN
  ,
  output logic [BIDS22_BID_W-1:0] bid_count,
  output logic [BIDS22_BID_W-1:0] win_count
`endif
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  bids22_agent_state_e     state, state_d;
  bids22_err_e             err_code;
  logic [BIDS22_BID_W-1:0] amt, amt_q, lead_amt;
  logic [15:0]             timer;
  logic                    give_up;
  logic                    latch_amt, set_lead, inc_timer, retract_c, timeout_c, cap_won;

  assign err_code = bids22_err_e'(err);

  bids22_bid_calc u_calc (
    .maxBid    (maxBid),
    .bid_step  (bid_step),
    .bid_limit (bid_limit),
    .balance   (balance),
    .amt       (amt),
    .give_up   (give_up)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // End of round outranks the enable; both discard whatever the state was doing.
  always_comb begin
    state_d   = state;
    latch_amt = 1'b0;
    set_lead  = 1'b0;
    inc_timer = 1'b0;
    retract_c = 1'b0;
    timeout_c = 1'b0;
    cap_won   = 1'b0;
    if (roundOver && state != ST_IDLE) begin
      cap_won = 1'b1;
      state_d = ST_IDLE;
    end else if (!agent_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_d = ST_EVAL;
        ST_EVAL: begin
          if (give_up) state_d = ST_STOP;
          else begin
            latch_amt = 1'b1;
            state_d   = ST_BID;
          end
        end
        ST_BID:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (err_code == ERR_FUNDS || err_code == ERR_INACTIVE) state_d = ST_STOP;
          else if (err_code == ERR_LOW) state_d = ST_EVAL;
          else if (ack) begin
            set_lead = 1'b1;
            state_d  = ST_LEAD;
          end else if (timer == TO_LAST) begin
            timeout_c = 1'b1;
            state_d   = ST_EVAL;
          end else inc_timer = 1'b1;
        end
        ST_LEAD: begin
          if (maxBid > 32'(lead_amt)) state_d = ST_EVAL;
          else if (retract_req) begin
            retract_c = 1'b1;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: state_d = ST_STOP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      amt_q       <= '0;
      lead_amt    <= '0;
      timer       <= '0;
      bid         <= 1'b0;
      bidAmt      <= '0;
      retract     <= 1'b0;
      leading     <= 1'b0;
      won         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (latch_amt) amt_q <= amt;
      if (set_lead)  lead_amt <= amt_q;
      if (state == ST_BID) timer <= '0;
      else if (inc_timer)  timer <= timer + 16'd1;
      bid         <= latch_amt;
      bidAmt      <= latch_amt ? amt : '0;
      retract     <= retract_c;
      leading     <= (state_d == ST_LEAD);
      busy        <= (state_d != ST_IDLE);
      timeout_err <= timeout_c;
      if (cap_won) won <= win;
      else if (state_d == ST_EVAL && state != ST_EVAL) won <= 1'b0;
    end
  end

`ifdef BIDS22_AGENT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bid_count <= '0;
      win_count <= '0;
    end else begin
      if (set_lead && bid_count != 16'hFFFF) bid_count <= bid_count + 16'd1;
      if (roundOver && win && win_count != 16'hFFFF) win_count <= win_count + 16'd1;
    end
  end
`endif

endmodule
